// File: rtl/calc_txn_feeder.sv
// Key buffer and transaction feeder for the calculator: holds incoming keys,
// issues each START..DONE group contiguously, then waits for finished/correct.
module calc_txn_feeder #(
  parameter int DEPTH    = 16,
  parameter int MAX_WAIT = 32
) (
  input  logic        clock,
  input  logic        reset_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_key,
  output logic [19:0] data,
  input  logic        finished,
  input  logic        correct,
  output logic        busy,
  output logic [7:0]  txn_ok,
  output logic [7:0]  txn_bad,
  output logic [2:0]  err
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [3:0]    OP_START = 4'h1;
  localparam logic [3:0]    OP_ENTER = 4'h2;
  localparam logic [3:0]    OP_ARITH = 4'h4;
  localparam logic [3:0]    OP_DONE  = 4'h8;
  localparam logic [19:0]   IDLE_KEY = 20'h00000;
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [19:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   done_pending;
  logic [WW-1:0] wait_cnt;
  logic          ready_en;
  logic          full, push, push_store, pop;
  logic          head_done, done_in, done_out, timeout;
  logic [19:0]   head;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_START, OP_ENTER, OP_ARITH, OP_DONE: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_done  = (head[19:16] == OP_DONE);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = ready_en & ~full & (state != FLUSH);
  assign push       = in_valid & in_ready;
  assign push_store = push & is_legal(in_key[19:16]);
  assign done_in    = push_store & (in_key[19:16] == OP_DONE);
  assign done_out   = pop & head_done;
  assign busy       = (state != IDLE);
  assign timeout    = (state == WAIT) & ~finished & (wait_cnt == WAIT_MAX);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (done_pending != '0) begin
          pop       = 1'b1;
          state_nxt = head_done ? WAIT : ISSUE;
        end else if (full) begin
          state_nxt = FLUSH;
        end
      end
      ISSUE: begin
        pop = 1'b1;
        if (head_done) state_nxt = WAIT;
      end
      WAIT: begin
        if (finished || wait_cnt == WAIT_MAX) state_nxt = IDLE;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state        <= IDLE;
      ready_en     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      done_pending <= '0;
      wait_cnt     <= '0;
      data         <= IDLE_KEY;
      txn_ok       <= 8'h00;
      txn_bad      <= 8'h00;
      err          <= 3'b000;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      data     <= pop ? head : IDLE_KEY;
      err      <= {timeout, (state == IDLE) && (state_nxt == FLUSH), push & ~push_store};

      // A flush discards everything; nothing can be pushed or popped in that cycle
      if (state == FLUSH) begin
        rd_ptr       <= wr_ptr;
        done_pending <= '0;
      end else begin
        if (push_store) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)        rd_ptr <= rd_ptr + PTR_ONE;
        if (done_in && !done_out)      done_pending <= done_pending + PTR_ONE;
        else if (done_out && !done_in) done_pending <= done_pending - PTR_ONE;
      end

      if (state_nxt == WAIT) wait_cnt <= (state == WAIT) ? wait_cnt + WAIT_ONE : WAIT_ONE;
      else                   wait_cnt <= '0;

      if (state == WAIT && finished) begin
        if (correct) txn_ok  <= sat_inc(txn_ok);
        else         txn_bad <= sat_inc(txn_bad);
      end else if (timeout) begin
        txn_bad <= sat_inc(txn_bad);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_store) mem[wr_ptr[AW-1:0]] <= in_key;
  end

endmodule

// File: tb/tb_calc_txn_feeder.sv
// Directed bench for calc_txn_feeder: hand-computed key sequences, counters,
// error pulses, flush, timeout, asynchronous reset and counter saturation.
module tb_calc_txn_feeder;

  logic        clock;
  logic        reset_N;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_key;
  logic [19:0] data;
  logic        finished;
  logic        correct;
  logic        busy;
  logic [7:0]  txn_ok;
  logic [7:0]  txn_bad;
  logic [2:0]  err;

  int passed = 0;
  int total  = 0;

  calc_txn_feeder #(.DEPTH(16), .MAX_WAIT(32)) dut (
    .clock    (clock),
    .reset_N  (reset_N),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_key   (in_key),
    .data     (data),
    .finished (finished),
    .correct  (correct),
    .busy     (busy),
    .txn_ok   (txn_ok),
    .txn_bad  (txn_bad),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [19:0] k);
    in_valid = 1'b1;
    in_key   = k;
    tick();
    in_valid = 1'b0;
    in_key   = 20'h0;
  endtask

  initial begin
    reset_N  = 1'b0;
    in_valid = 1'b0;
    in_key   = 20'h0;
    finished = 1'b0;
    correct  = 1'b0;
    tick();
    tick();
    check("rst_data", data, 20'h0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ok", txn_ok, 0);
    check("rst_bad", txn_bad, 0);
    check("rst_err", err, 0);
    reset_N = 1'b1;
    #1;
    check("ready_before_edge", in_ready, 0);
    tick();
    check("ready_after_edge", in_ready, 1);

    // Basic four-key transaction, correct result
    push(20'h10005);
    push(20'h20003);
    push(20'h40001);
    push(20'h80001);
    check("a_hold", data, 20'h0);
    tick(); check("a_k0", data, 20'h10005); check("a_busy", busy, 1);
    tick(); check("a_k1", data, 20'h20003);
    tick(); check("a_k2", data, 20'h40001);
    tick(); check("a_k3", data, 20'h80001);
    tick(); check("a_idle", data, 20'h0); check("a_wait_busy", busy, 1);
    finished = 1'b1; correct = 1'b1;
    tick();
    finished = 1'b0; correct = 1'b0;
    check("a_ok", txn_ok, 1);
    check("a_bad", txn_bad, 0);
    check("a_done_busy", busy, 0);

    // Gap inside a transaction: nothing leaves until DONE is buffered
    push(20'h10007);
    push(20'h20002);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("b_gap_data", data, 20'h0);
      check("b_gap_busy", busy, 0);
    end
    push(20'h40002);
    push(20'h80000);
    check("b_hold", data, 20'h0);
    tick(); check("b_k0", data, 20'h10007);
    tick(); check("b_k1", data, 20'h20002);
    tick(); check("b_k2", data, 20'h40002);
    tick(); check("b_k3", data, 20'h80000);
    finished = 1'b1; correct = 1'b0;
    tick();
    finished = 1'b0;
    check("b_bad", txn_bad, 1);
    check("b_ok", txn_ok, 1);
    check("b_data", data, 20'h0);

    // Illegal op dropped mid-transaction
    push(20'h10001);
    push(20'h3ABCD);
    check("c_err0", err, 3'b001);
    push(20'h20009);
    check("c_err0_clear", err, 3'b000);
    push(20'h40004);
    push(20'h80002);
    tick(); check("c_k0", data, 20'h10001);
    tick(); check("c_k1", data, 20'h20009);
    tick(); check("c_k2", data, 20'h40004);
    tick(); check("c_k3", data, 20'h80002);
    finished = 1'b1; correct = 1'b1;
    tick();
    finished = 1'b0; correct = 1'b0;
    check("c_ok", txn_ok, 2);

    // Timeout after 32 WAIT cycles
    push(20'h10011);
    push(20'h80000);
    tick(); check("d_k0", data, 20'h10011);
    tick(); check("d_k1", data, 20'h80000);
    for (int i = 0; i < 31; i++) begin
      tick();
      check("d_wait_busy", busy, 1);
      check("d_wait_err", err, 0);
    end
    tick();
    check("d_timeout_err", err, 3'b100);
    check("d_timeout_busy", busy, 0);
    check("d_bad", txn_bad, 2);
    tick();
    check("d_err_clear", err, 0);

    // Deadlock flush: DEPTH keys with no DONE
    for (int i = 0; i < 16; i++) push(20'h20000 | 20'(i));
    check("e_full_ready", in_ready, 0);
    tick();
    check("e_flush_ready", in_ready, 0);
    check("e_flush_err", err, 3'b010);
    check("e_flush_busy", busy, 1);
    tick();
    check("e_after_ready", in_ready, 1);
    check("e_after_err", err, 0);
    check("e_after_busy", busy, 0);
    push(20'h10042);
    push(20'h80042);
    tick(); check("e_k0", data, 20'h10042);
    tick(); check("e_k1", data, 20'h80042);
    finished = 1'b1; correct = 1'b1;
    tick();
    finished = 1'b0; correct = 1'b0;
    check("e_ok", txn_ok, 3);

    // Asynchronous reset during ISSUE
    push(20'h1000A);
    push(20'h2000B);
    push(20'h4000C);
    push(20'h8000D);
    tick(); check("f_k0", data, 20'h1000A);
    tick(); check("f_k1", data, 20'h2000B);
    reset_N = 1'b0;
    #1;
    check("f_rst_data", data, 20'h0);
    check("f_rst_busy", busy, 0);
    check("f_rst_ok", txn_ok, 0);
    check("f_rst_bad", txn_bad, 0);
    check("f_rst_ready", in_ready, 0);
    check("f_rst_err", err, 0);
    #1;
    reset_N = 1'b1;
    tick();
    check("f_ready", in_ready, 1);
    check("f_no_issue", data, 20'h0);
    check("f_idle", busy, 0);
    push(20'h10077);
    push(20'h80077);
    tick(); check("f_k0_new", data, 20'h10077);
    tick(); check("f_k1_new", data, 20'h80077);
    finished = 1'b1; correct = 1'b1;
    tick();
    check("f_ok", txn_ok, 1);

    // Saturation of txn_ok with single-DONE transactions
    for (int i = 0; i < 254; i++) begin
      push(20'h80000);
      tick();
      tick();
    end
    check("g_ok_255", txn_ok, 8'hFF);
    push(20'h80000);
    tick();
    tick();
    check("g_ok_sat", txn_ok, 8'hFF);
    check("g_bad", txn_bad, 0);
    finished = 1'b0; correct = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
